// File: rtl/sync_handshake_responder_if.sv
// Handshake bundle between the toggle-crossing source, this responder and the
// downstream consumer. The responder uses the slave view; whoever drives the
// request toggle and the dequeue strobe uses the master view.
interface sync_handshake_responder_if #(
    parameter int width = 8
);
    logic             sTOGGLE;  // request toggle from the source domain
    logic [width-1:0] sDATA;    // source data word, stable while a request is open
    logic             dACK;     // acknowledge toggle back to the source domain
    logic             dVALID;   // dDATA holds an unconsumed word
    logic [width-1:0] dDATA;    // captured word
    logic             dDEQ;     // downstream consumes dDATA
    logic             dERR;     // sticky protocol-violation flag
    logic [15:0]      dCOUNT;   // words dequeued, wrapping

    modport slave (
        input  sTOGGLE, sDATA, dDEQ,
        output dACK, dVALID, dDATA, dERR, dCOUNT
    );

    modport master (
        output sTOGGLE, sDATA, dDEQ,
        input  dACK, dVALID, dDATA, dERR, dCOUNT
    );
endinterface

// File: rtl/sync_handshake_responder.sv
// Destination end of a toggle request/acknowledge crossing. The incoming
// request toggle is synchronized, each detected edge captures the source word,
// the word is offered downstream with valid/dequeue, and the acknowledge toggle
// flips only once the word is consumed, giving end-to-end backpressure.
// Everything here runs on dCLK; sTOGGLE is the only asynchronous input and
// sDATA is stable whenever it is sampled. sync_stages must be in 2..4.
module sync_handshake_responder #(
    parameter int   width       = 8,
    parameter logic init        = 1'b0,
    parameter int   sync_stages = 2
) (
    input logic                       dCLK,
    input logic                       dRST,
    sync_handshake_responder_if.slave bus
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t                 r_state;
    logic [sync_stages-1:0] r_sync;
    logic                   r_last_state;
    logic                   r_ack;
    logic                   r_valid;
    logic                   r_err;
    logic [width-1:0]       r_data;
    logic [15:0]            r_count;

    logic                   w_sync_out;
    logic                   w_req_edge;

    // A request is any change of the synchronized toggle since last cycle.
    assign w_sync_out = r_sync[sync_stages-1];
    assign w_req_edge = w_sync_out ^ r_last_state;

    // Synchronizer chain for sTOGGLE plus the last-seen toggle level.
    always_ff @(posedge dCLK or posedge dRST) begin
        if (dRST) begin
            r_sync       <= {sync_stages{init}};
            r_last_state <= init;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values, so the chain shifts one stage per clock.
            r_sync       <= {r_sync[sync_stages-2:0], bus.sTOGGLE};
            r_last_state <= w_sync_out;
        end
    end

    // Capture/hold FSM with registered valid, data, acknowledge, error and count.
    always_ff @(posedge dCLK or posedge dRST) begin
        if (dRST) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ack   <= init;
            r_err   <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_edge) begin
                        r_data  <= bus.sDATA;
                        r_valid <= 1'b1;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    // A second request before the first is acknowledged is a
                    // source violation: the held word wins, the new one is lost.
                    if (w_req_edge) begin
                        r_err <= 1'b1;
                    end
                    if (bus.dDEQ) begin
                        r_valid <= 1'b0;
                        r_ack   <= ~r_ack;
                        r_count <= r_count + 16'd1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dACK   = r_ack;
    assign bus.dVALID = r_valid;
    assign bus.dDATA  = r_data;
    assign bus.dERR   = r_err;
    assign bus.dCOUNT = r_count;

endmodule

// File: tb/tb_sync_handshake_responder.sv
// Directed bench for sync_handshake_responder. Stimulus pushes the words it
// expects to see dequeued; a negedge monitor pops and compares them whenever a
// dequeue is presented. Control outputs are checked directly against
// bench-tracked acknowledge and count values.
module tb_sync_handshake_responder;

    logic       clk = 1'b0;
    logic       rst;
    int         n_checks = 0;
    int         n_err    = 0;
    logic [7:0] exp_q[$];
    logic       exp_ack;
    logic [15:0] exp_count;

    sync_handshake_responder_if #(.width(8)) bus ();

    sync_handshake_responder #(
        .width       (8),
        .init        (1'b0),
        .sync_stages (2)
    ) dut (
        .dCLK (clk),
        .dRST (rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to 2 time units after the next rising edge(s).
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Source side: present a word and flip the request toggle.
    task automatic send(input logic [7:0] d, input bit track);
        bus.sDATA   = d;
        bus.sTOGGLE = ~bus.sTOGGLE;
        if (track) exp_q.push_back(d);
    endtask

    task automatic wait_valid(input string name);
        int k;
        k = 0;
        while (bus.dVALID !== 1'b1 && k < 10) begin
            cyc();
            k++;
        end
        check(name, bus.dVALID, 1'b1);
    endtask

    // One-cycle dequeue pulse, then confirm the acknowledge and count moved once.
    task automatic deq(input string name);
        bus.dDEQ = 1'b1;
        cyc();
        bus.dDEQ  = 1'b0;
        exp_ack   = ~exp_ack;
        exp_count = exp_count + 16'd1;
        check({name, "_valid"}, bus.dVALID, 1'b0);
        check({name, "_ack"},   bus.dACK,   exp_ack);
        check({name, "_count"}, bus.dCOUNT, exp_count);
    endtask

    task automatic xfer(input logic [7:0] d, input string name);
        send(d, 1'b1);
        wait_valid({name, "_cap"});
        deq(name);
    endtask

    // Scoreboard monitor: every presented dequeue must carry the next expected word.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.dVALID === 1'b1 && bus.dDEQ === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL mon_unexpected: dequeue of %h with nothing expected", bus.dDATA);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("mon_data", bus.dDATA, e);
            end
        end
    end

    initial begin
        int bad;
        int k;

        rst         = 1'b1;
        bus.sTOGGLE = 1'b0;
        bus.sDATA   = 8'h00;
        bus.dDEQ    = 1'b0;
        exp_ack     = 1'b0;
        exp_count   = 16'h0000;

        // Reset and idle
        #1;
        check("rst_valid", bus.dVALID, 1'b0);
        check("rst_ack",   bus.dACK,   1'b0);
        check("rst_data",  bus.dDATA,  8'h00);
        cyc(3);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            check("idle_valid", bus.dVALID, 1'b0);
            check("idle_ack",   bus.dACK,   1'b0);
            check("idle_err",   bus.dERR,   1'b0);
            check("idle_count", bus.dCOUNT, 16'h0000);
        end

        // Single transfer with exact two-stage latency
        send(8'hA5, 1'b1);
        cyc();
        cyc();
        check("lat_e1_valid", bus.dVALID, 1'b0);
        cyc();
        check("lat_e2_valid", bus.dVALID, 1'b1);
        check("lat_e2_data",  bus.dDATA,  8'hA5);
        cyc(2);
        deq("single");
        check("single_data_kept", bus.dDATA, 8'hA5);

        // Request edge lands in the first IDLE cycle after a dequeue
        send(8'hC1, 1'b1);
        wait_valid("b2b_first");
        send(8'hC2, 1'b1);
        cyc();
        bus.dDEQ = 1'b1;
        cyc();
        bus.dDEQ  = 1'b0;
        exp_ack   = ~exp_ack;
        exp_count = exp_count + 16'd1;
        check("b2b_deq_valid", bus.dVALID, 1'b0);
        check("b2b_deq_ack",   bus.dACK,   exp_ack);
        cyc();
        check("b2b_cap_valid", bus.dVALID, 1'b1);
        check("b2b_cap_data",  bus.dDATA,  8'hC2);
        check("b2b_err",       bus.dERR,   1'b0);
        deq("b2b_second");

        // Burst: source re-flips as soon as it sees the acknowledge
        bus.dDEQ = 1'b1;
        for (int i = 0; i < 100; i++) begin
            send(8'(i) ^ 8'h5A, 1'b1);
            k = 0;
            while (bus.dACK === exp_ack && k < 20) begin
                cyc();
                k++;
            end
            exp_ack   = ~exp_ack;
            exp_count = exp_count + 16'd1;
            check("burst_ack", bus.dACK, exp_ack);
        end
        bus.dDEQ = 1'b0;
        cyc();
        check("burst_count", bus.dCOUNT, 16'd103);

        // Counter wrap, starting from a preloaded count near the top
        force dut.r_count = 16'hFFFD;
        cyc();
        release dut.r_count;
        exp_count = 16'hFFFD;
        check("wrap_preload", bus.dCOUNT, 16'hFFFD);
        xfer(8'h01, "wrap_a");
        xfer(8'h02, "wrap_b");
        check("wrap_top", bus.dCOUNT, 16'hFFFF);
        xfer(8'h03, "wrap_c");
        check("wrap_zero", bus.dCOUNT, 16'h0000);
        check("wrap_err",  bus.dERR,   1'b0);

        // Backpressure: word held for 50 cycles, then exactly one acknowledge
        send(8'h3C, 1'b1);
        wait_valid("bp_cap");
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            cyc();
            if (bus.dVALID !== 1'b1 || bus.dDATA !== 8'h3C || bus.dACK !== exp_ack) bad++;
        end
        check("bp_stall_cycles", bad, 0);
        deq("bp");
        cyc(5);
        check("bp_single_flip", bus.dACK, exp_ack);

        // Dequeue with nothing valid is ignored
        bus.dDEQ = 1'b1;
        cyc(5);
        bus.dDEQ = 1'b0;
        check("idle_deq_ack",   bus.dACK,   exp_ack);
        check("idle_deq_count", bus.dCOUNT, exp_count);
        check("idle_deq_err",   bus.dERR,   1'b0);

        // Overrun: second request while holding is dropped and flagged
        send(8'h11, 1'b1);
        wait_valid("ovr_cap");
        send(8'h22, 1'b0);
        cyc(3);
        check("ovr_err",   bus.dERR,   1'b1);
        check("ovr_data",  bus.dDATA,  8'h11);
        check("ovr_valid", bus.dVALID, 1'b1);
        check("ovr_ack",   bus.dACK,   exp_ack);
        deq("ovr");
        cyc(5);
        check("ovr_err_sticky", bus.dERR,   1'b1);
        check("ovr_no_recap",   bus.dVALID, 1'b0);
        check("ovr_ack_once",   bus.dACK,   exp_ack);

        // Reset mid-operation clears everything without a clock edge
        send(8'h77, 1'b0);
        wait_valid("mid_cap");
        check("mid_data", bus.dDATA, 8'h77);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.dVALID, 1'b0);
        check("mid_rst_data",  bus.dDATA,  8'h00);
        check("mid_rst_ack",   bus.dACK,   1'b0);
        check("mid_rst_err",   bus.dERR,   1'b0);
        check("mid_rst_count", bus.dCOUNT, 16'h0000);
        bus.sTOGGLE = 1'b0;
        exp_ack     = 1'b0;
        exp_count   = 16'h0000;
        cyc(3);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (bus.dVALID !== 1'b0 || bus.dACK !== 1'b0) bad++;
        end
        check("post_rst_quiet", bad, 0);
        xfer(8'h5E, "post_rst");

        cyc(2);
        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_handshake_responder.md
Name: sync_handshake_responder

Overview:
- Destination-end responder for the toggle-based request/acknowledge crossing protocol.
- The source side flips a request toggle and holds a data word stable until it sees the acknowledge toggle flip.
- This block runs entirely in the destination clock domain. It synchronizes the incoming toggle, captures the data word, presents it downstream with a valid/dequeue handshake, and returns an acknowledge toggle only after the word is consumed.
- This gives end-to-end backpressure across the crossing. It also tracks transfer count and protocol violations.

Parameters:
- width, 8, bit width of the transferred data word.
- init, 1'b0, reset value of the request synchronizer chain, last-state register and acknowledge toggle; must match the source side's init.
- sync_stages, 2, number of synchronizer flops on sTOGGLE; legal range 2..4.

Ports:
- dCLK  input  1  destination clock.
- dRST  input  1  asynchronous, active-high reset; all state returns to reset values immediately.
- sTOGGLE  input  1  request toggle from the source domain (asynchronous to dCLK).
- sDATA  input  width  data from the source domain; stable from sTOGGLE flip until dACK flip is seen by the source.
- dACK  output  1  acknowledge toggle back to the source domain; registered.
- dVALID  output  1  dDATA holds an unconsumed word.
- dDATA  output  width  captured word; registered.
- dDEQ  input  1  downstream consumes dDATA; honoured only when dVALID=1.
- dERR  output  1  sticky protocol-violation flag.
- dCOUNT  output  16  number of words dequeued; wraps.

Behaviour:
- Reset (dRST=1, async):
  - sync chain, dLastState and dACK all go to init.
  - dVALID=0, dDATA=0, dERR=0, dCOUNT=0, FSM=IDLE.
  - Reset mid-transfer discards any held word; no acknowledge is issued.
- Synchronizer:
  - sTOGGLE passes through sync_stages flops.
  - reqEdge = (last sync flop != dLastState).
  - dLastState <= last sync flop every cycle.
- FSM state IDLE:
  - On reqEdge: dDATA <= sDATA, dVALID <= 1, go to HOLD.
- FSM state HOLD:
  - On dDEQ=1: dVALID <= 0, dACK <= ~dACK, dCOUNT <= dCOUNT+1 (0xFFFF wraps to 0x0000), go to IDLE.
  - dDATA keeps its value after the dequeue until the next capture.
- Latency:
  - sTOGGLE flip before edge E0 gives dVALID=1 after edge E(sync_stages).
  - With sync_stages=2, that is 3 dCLK rising edges including E0.
  - dDEQ sampled at edge Ek gives dVALID=0 and dACK flipped after Ek. There is no combinational path from dDEQ to any output.
- Violations:
  - reqEdge while in HOLD is a source protocol violation. It sets dERR <= 1.
  - The held dDATA is not overwritten and the new word is dropped.
  - No dACK is generated for the dropped word.
  - If dDEQ=1 in the same cycle, the dequeue proceeds normally: dVALID=0, ack flips once, count increments once.
- dDEQ while dVALID=0 is ignored: no ack, no count, no error.
- dERR clears only on reset.
- Back-to-back transfers: a new reqEdge in the first IDLE cycle after a dequeue is captured normally. There is no dead cycle in the responder.

Test Plan:
- Reset and idle: assert dRST for 3 cycles, release, hold sTOGGLE=0 for 20 cycles -> dVALID=0, dACK=0, dERR=0, dCOUNT=0 throughout.
- Single transfer (sync_stages=2): sDATA=8'hA5, flip sTOGGLE 0->1 before edge E0 -> dVALID=1 and dDATA=8'hA5 after E2. Pulse dDEQ at E5 -> dVALID=0, dACK=1, dCOUNT=1 after E5.
- Backpressure: capture 8'h3C, hold dDEQ=0 for 50 cycles -> dVALID stays 1, dDATA=8'h3C, dACK unchanged. Then dDEQ=1 -> exactly one dACK flip.
- Overrun: capture 8'h11, then while dVALID=1 flip sTOGGLE again with sDATA=8'h22 -> dERR=1 from then until reset, dDATA remains 8'h11. After dDEQ, dACK flips once and dCOUNT increments once.
- Wrap and back-to-back: preload by running 65535 transfers, each re-flipping the toggle immediately on seeing dACK -> dCOUNT=16'hFFFF. One more transfer -> dCOUNT=16'h0000, dERR=0.
- Reset mid-operation: assert dRST while dVALID=1 with dDATA=8'h77 -> dVALID=0, dDATA=0, dACK=init immediately, without waiting for a clock edge. After release with sTOGGLE held at init, no spurious capture occurs.
